seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Time-multiplexing controller for the BASYS2 four-digit seven-segment display. It holds four 4-bit digit values and scans one digit at a time through a single shared hex-to-segment decoder. It drives active-low anodes with a fixed dwell time and inserts a blanking gap between digits to prevent ghosting. It sits between the switch/encoder logic, which writes digit values, and the board's `seg7`/`an` pins.

## Interface
- `REFRESH_DIV`, default 12500. Cycles per digit slot, including blanking. At 50 MHz this gives 4 kHz slots and a 1 kHz frame. Must satisfy `REFRESH_DIV > BLANK_CYC`.
- `BLANK_CYC`, default 250. Cycles at the end of each slot with all anodes off. Must be ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  scan enable. When 0 the display is dark and the scan is held.
- `wr_en`  in  1  digit write strobe, one cycle.
- `wr_addr`  in  2  digit index to write (0 = rightmost).
- `wr_data`  in  4  hex value to write.
- `blank_mask`  in  4  bit i = 1 forces digit i dark while its anode is active.
- `seg7`  out  7  active-low segments, order gfedcba (`seg7[6]` = g). Registered.
- `an`  out  4  active-low anodes, `an[i]` = digit i. Registered.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- **Digit registers:** `dig[0..3]`, each 4 bits, all reset to 0.
  - `wr_en` writes `dig[wr_addr] <= wr_data`. A write is always accepted; there is no backpressure.
- **Scan state machine**, two states:
  - `SHOW`: `an` has only bit `idx` low. `seg7` = decode(`dig[idx]`), or 7'h7F if `blank_mask[idx]`.
  - `GAP`: `an` = 4'b1111 and `seg7` = 7'h7F.
- **Slot counter** `cnt` counts 0..REFRESH_DIV-1 in every state.
  - `SHOW` → `GAP` when `cnt == REFRESH_DIV-BLANK_CYC-1`.
  - `GAP` → `SHOW` when `cnt == REFRESH_DIV-1`. On this transition `cnt` wraps to 0 and `idx` becomes `(idx+1) mod 4`.
  - `frame_tick` pulses on the `GAP` → `SHOW` transition where `idx` wraps 3 → 0.
- **Enable:** `en` = 0 forces state `GAP`, holds `cnt` = 0, and holds `idx`. When `en` returns to 1, the next cycle enters `SHOW` for the same `idx` with a full slot.
- **Decoder**, active-low:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (all hex)
- **Reset**, mid-operation included: takes effect immediately.
  - State `GAP`, `cnt` = 0, `idx` = 0.
  - `an` = 4'b1111, `seg7` = 7'h7F, `frame_tick` = 0.
  - All `dig` cleared to 0.
- **Write to the digit currently shown:** new segments appear without waiting for the next slot.
- **Simultaneous write and slot change:** the decoder uses the post-write value of the new `idx`.

## Timing
- Outputs are registered.
- Write latency: for a digit in `SHOW`, `seg7` reflects a write sampled at edge k on edge k+1. This holds even when `wr_addr == idx`.
- After reset release with `en` = 1, the first `SHOW` for digit 0 starts on the second rising edge. It lasts `REFRESH_DIV-BLANK_CYC` cycles, followed by `BLANK_CYC` cycles of `GAP`.
- Anode and segment changes occur on the same edge. No anode is ever active during a `GAP` cycle.
- Frame period is `4*REFRESH_DIV` cycles, with `frame_tick` exactly once per frame.

## Structure
- Shared package `seg7_pkg` holds:
  - `SEG_BLANK` = 7'h7F and `AN_OFF` = 4'b1111
  - the state enum {`SHOW`, `GAP`}
  - the 16-entry hex segment constant table
- One sub-module, `seg7_hex_decode`: purely combinational 4-bit → 7-bit lookup, instantiated once and fed by the `idx` mux.

## Test plan
All scenarios use `REFRESH_DIV` = 8 and `BLANK_CYC` = 2.
- **Reset/idle:** assert `rst` mid-slot → same cycle `an` = 1111, `seg7` = 7F; after release all four digits show 7'h40, each for 6 cycles followed by 2 dark cycles.
- **Full decode:** write 0..F to digit 2 in turn while it is shown → `seg7` follows the table one cycle after each write, `an` = 1011.
- **Scan order:** write `dig` = {3,2,1,0} → `an` sequence 1110, 1101, 1011, 0111 with `seg7` 40, 79, 24, 30; `frame_tick` once per 32 cycles.
- **Blank mask:** `blank_mask` = 0100 → during digit 2's slot `an` = 1011 but `seg7` = 7F; the other digits are unaffected.
- **Enable hold:** drop `en` during digit 1 `SHOW` for 5 cycles → `an` = 1111 throughout; on re-enable digit 1 resumes with a full 6-cycle `SHOW`.
- **Boundary write:** write to digit 3 on the cycle of the `GAP` → `SHOW` transition into digit 3 → the first `SHOW` cycle already shows the new value.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment scan controller.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef enum logic {
    SHOW,
    GAP
  } scan_state_e;

  // Active-low gfedcba patterns for hex 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-segment lookup, active-low, gfedcba order.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment driver with per-slot blanking gap.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 12500,
  parameter int unsigned BLANK_CYC   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [3:0] blank_mask,
  output logic [6:0] seg7,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             wrap;
  logic [3:0]       dig_q [4];
  logic [6:0]       seg_dec;

  seg7_hex_decode u_dec (
    .hex (dig_q[idx_q]),
    .seg (seg_dec)
  );

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!en) begin
      state_d = GAP;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SHOW: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHOW_LAST) state_d = GAP;
        end
        GAP: begin
          // A GAP parked at cnt 0 (after reset or disable) restarts the same digit.
          if (cnt_q == '0) begin
            state_d = SHOW;
          end else if (cnt_q == SLOT_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            wrap    = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = GAP;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GAP;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the digit store is tiny and must read as zero after reset, so it is reset like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) dig_q[i] <= '0;
    end else if (wr_en) begin
      dig_q[wr_addr] <= wr_data;
    end
  end

  // Output stage follows the current scan state; en gates it so a disable goes dark at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg7       <= SEG_BLANK;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (en && state_q == SHOW) begin
        an   <= ~(4'b0001 << idx_q);
        seg7 <= blank_mask[idx_q] ? SEG_BLANK : seg_dec;
      end else begin
        an   <= AN_OFF;
        seg7 <= SEG_BLANK;
      end
    end
  end

endmodule
